// File: rtl/dsi_dma_pkg.sv
// Shared types and DMA control-register map for the DSI frame DMA sequencer.
package dsi_dma_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        W_ADDR = 3'd1,
        W_LEN  = 3'd2,
        W_EN   = 3'd3,
        STREAM = 3'd4,
        W_DIS  = 3'd5
    } state_t;

    localparam logic [4:0] DMA_REG_ADDR = 5'h00;
    localparam logic [4:0] DMA_REG_LEN  = 5'h04;
    localparam logic [4:0] DMA_REG_EN   = 5'h08;

endpackage

// File: rtl/dsi_frame_dma_sched.sv
// Per-frame DMA sequencer: picks the newest finished buffer on frame_start,
// programs the stream DMA over Avalon-MM, then waits for the frame's beats.
module dsi_frame_dma_sched
    import dsi_dma_pkg::*;
#(
    parameter int ADDR_WIDTH  = 24,
    parameter int NUM_BUFFERS = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cfg_enable,
    input  logic [ADDR_WIDTH-1:0] cfg_base_addr,
    input  logic [ADDR_WIDTH-1:0] cfg_buf_stride,
    input  logic [29:0]           cfg_frame_words,
    input  logic                  frame_start,
    input  logic                  prod_done,
    input  logic [1:0]            prod_buf_idx,
    output logic [4:0]            dma_address,
    output logic                  dma_write,
    output logic [31:0]           dma_writedata,
    output logic [3:0]            dma_byteenable,
    output logic                  dma_read,
    input  logic                  dma_waitrequest,
    input  logic                  st_valid,
    input  logic                  st_ready,
    output logic                  busy,
    output logic                  frame_done,
    output logic                  underrun,
    output logic [1:0]            cur_buf,
    output logic [15:0]           drop_cnt
);

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    state_t                state_q, state_d;
    logic [1:0]            cur_buf_q, cur_buf_d;
    logic [1:0]            latest_buf_q, latest_buf_d;
    logic                  fresh_q, fresh_d;
    logic [ADDR_WIDTH-1:0] frame_addr_q, frame_addr_d;
    logic [29:0]           words_q, words_d;
    logic [29:0]           beat_q, beat_d;
    logic [15:0]           drop_cnt_q, drop_cnt_d;
    logic                  frame_done_q, frame_done_d;
    logic                  underrun_q, underrun_d;

    logic       wr_accept;
    logic       accept;
    logic       prod_ok;
    logic [1:0] sel_buf;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            cur_buf_q    <= 2'd0;
            latest_buf_q <= 2'd0;
            fresh_q      <= 1'b0;
            frame_addr_q <= '0;
            words_q      <= 30'd0;
            beat_q       <= 30'd0;
            drop_cnt_q   <= 16'd0;
            frame_done_q <= 1'b0;
            underrun_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cur_buf_q    <= cur_buf_d;
            latest_buf_q <= latest_buf_d;
            fresh_q      <= fresh_d;
            frame_addr_q <= frame_addr_d;
            words_q      <= words_d;
            beat_q       <= beat_d;
            drop_cnt_q   <= drop_cnt_d;
            frame_done_q <= frame_done_d;
            underrun_q   <= underrun_d;
        end
    end

    // Write request is a pure function of state, so address/data stay put
    // for as long as the slave stalls.
    always_comb begin
        dma_write     = 1'b0;
        dma_address   = 5'h00;
        dma_writedata = 32'h0;
        case (state_q)
            W_ADDR: begin
                dma_write     = 1'b1;
                dma_address   = DMA_REG_ADDR;
                dma_writedata = 32'(frame_addr_q);
            end
            W_LEN: begin
                dma_write     = 1'b1;
                dma_address   = DMA_REG_LEN;
                dma_writedata = {2'b00, words_q};
            end
            W_EN: begin
                dma_write     = 1'b1;
                dma_address   = DMA_REG_EN;
                dma_writedata = 32'h1;
            end
            W_DIS: begin
                dma_write     = 1'b1;
                dma_address   = DMA_REG_EN;
                dma_writedata = 32'h0;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        cur_buf_d    = cur_buf_q;
        latest_buf_d = latest_buf_q;
        fresh_d      = fresh_q;
        frame_addr_d = frame_addr_q;
        words_d      = words_q;
        beat_d       = beat_q;
        drop_cnt_d   = drop_cnt_q;
        frame_done_d = 1'b0;
        underrun_d   = 1'b0;

        wr_accept = dma_write && !dma_waitrequest;
        prod_ok   = prod_done && (int'(prod_buf_idx) < NUM_BUFFERS);
        accept    = frame_start && (state_q == IDLE) && cfg_enable
                    && (cfg_frame_words != 30'd0);

        // A producer strobe in the accept cycle wins over the stored index.
        if (prod_ok)      sel_buf = prod_buf_idx;
        else if (fresh_q) sel_buf = latest_buf_q;
        else              sel_buf = cur_buf_q;

        if (prod_ok) begin
            latest_buf_d = prod_buf_idx;
            fresh_d      = 1'b1;
        end

        if (accept) begin
            cur_buf_d    = sel_buf;
            fresh_d      = 1'b0;
            frame_addr_d = cfg_base_addr + cfg_buf_stride * ADDR_WIDTH'(sel_buf);
            words_d      = cfg_frame_words;
            beat_d       = 30'd0;
            state_d      = W_ADDR;
        end else if (frame_start) begin
            underrun_d = 1'b1;
            drop_cnt_d = sat_inc16(drop_cnt_q);
        end

        case (state_q)
            W_ADDR: if (wr_accept) state_d = W_LEN;
            W_LEN:  if (wr_accept) state_d = W_EN;
            W_EN:   if (wr_accept) state_d = STREAM;
            STREAM: begin
                if (st_valid && st_ready) begin
                    beat_d = beat_q + 30'd1;
                    if (beat_q + 30'd1 == words_q) state_d = W_DIS;
                end
            end
            W_DIS: begin
                if (wr_accept) begin
                    state_d      = IDLE;
                    frame_done_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign dma_byteenable = 4'hF;
    assign dma_read       = 1'b0;
    assign busy           = (state_q != IDLE);
    assign frame_done     = frame_done_q;
    assign underrun       = underrun_q;
    assign cur_buf        = cur_buf_q;
    assign drop_cnt       = drop_cnt_q;

endmodule

// File: tb/tb_dsi_frame_dma_sched.sv
// Scoreboard bench for dsi_frame_dma_sched with a queue-based reference model.
module tb_dsi_frame_dma_sched;

    localparam int AW = 24;
    localparam int NB = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          cfg_enable;
    logic [AW-1:0] cfg_base_addr;
    logic [AW-1:0] cfg_buf_stride;
    logic [29:0]   cfg_frame_words;
    logic          frame_start;
    logic          prod_done;
    logic [1:0]    prod_buf_idx;
    logic [4:0]    dma_address;
    logic          dma_write;
    logic [31:0]   dma_writedata;
    logic [3:0]    dma_byteenable;
    logic          dma_read;
    logic          dma_waitrequest;
    logic          st_valid;
    logic          st_ready;
    logic          busy;
    logic          frame_done;
    logic          underrun;
    logic [1:0]    cur_buf;
    logic [15:0]   drop_cnt;

    dsi_frame_dma_sched #(.ADDR_WIDTH(AW), .NUM_BUFFERS(NB)) dut (
        .clk(clk), .rst(rst), .cfg_enable(cfg_enable),
        .cfg_base_addr(cfg_base_addr), .cfg_buf_stride(cfg_buf_stride),
        .cfg_frame_words(cfg_frame_words), .frame_start(frame_start),
        .prod_done(prod_done), .prod_buf_idx(prod_buf_idx),
        .dma_address(dma_address), .dma_write(dma_write),
        .dma_writedata(dma_writedata), .dma_byteenable(dma_byteenable),
        .dma_read(dma_read), .dma_waitrequest(dma_waitrequest),
        .st_valid(st_valid), .st_ready(st_ready), .busy(busy),
        .frame_done(frame_done), .underrun(underrun), .cur_buf(cur_buf),
        .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          kind;   // 0 = register write, 1 = frame_done
        logic [4:0]  a;
        logic [31:0] d;
    } ev_t;

    ev_t sbq[$];

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model state
    int          m_latest = 0;
    bit          m_fresh  = 0;
    int          m_cur    = 0;
    bit          m_busy   = 0;
    int          m_drop   = 0;
    int          m_und    = 0;
    int          und_seen = 0;
    bit          streaming = 0;
    int          stall_mode = 0;
    int          stall_cnt  = 0;
    bit          hold = 0;
    logic [4:0]  ha;
    logic [31:0] hd;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void push_ev(input int kind, input logic [4:0] a, input logic [31:0] d);
        ev_t e;
        e.kind = kind; e.a = a; e.d = d;
        sbq.push_back(e);
    endfunction

    // Monitor: pops the scoreboard whenever the DUT presents an event.
    always @(negedge clk) begin
        if (rst) begin
            hold = 0;
        end else begin
            if (dma_write) begin
                if (!hold) begin
                    hold = 1; ha = dma_address; hd = dma_writedata;
                end else begin
                    check("hold_addr", 32'(dma_address), 32'(ha));
                    check("hold_data", dma_writedata, hd);
                end
                if (!dma_waitrequest) begin
                    hold = 0;
                    check("byteenable", 32'(dma_byteenable), 32'hF);
                    check("dma_read", 32'(dma_read), 32'h0);
                    if (sbq.size() == 0) begin
                        n_chk++; n_fail++;
                        $display("FAIL extra_write: got addr 0x%0h data 0x%0h expected none", dma_address, dma_writedata);
                    end else begin
                        ev_t e;
                        e = sbq.pop_front();
                        check("write_kind", 32'd0, 32'(e.kind));
                        check("write_addr", 32'(dma_address), 32'(e.a));
                        check("write_data", dma_writedata, e.d);
                        if (e.a == 5'h08 && e.d == 32'h1) streaming = 1;
                    end
                end
            end
            if (frame_done) begin
                check("busy_at_done", 32'(busy), 32'h0);
                if (sbq.size() == 0) begin
                    n_chk++; n_fail++;
                    $display("FAIL extra_frame_done: got 1 expected 0");
                end else begin
                    ev_t e;
                    e = sbq.pop_front();
                    check("done_kind", 32'd1, 32'(e.kind));
                end
                m_busy = 0;
            end
            if (underrun) und_seen++;
        end
    end

    // Slave stall generator
    always @(posedge clk) begin
        #1;
        if (rst || !dma_write) begin
            dma_waitrequest = 1'b0;
            stall_cnt = 0;
        end else if (stall_mode == 1) begin
            if (stall_cnt < 5) begin dma_waitrequest = 1'b1; stall_cnt++; end
            else begin dma_waitrequest = 1'b0; stall_cnt = 0; end
        end else if (stall_mode == 2) begin
            dma_waitrequest = 1'($urandom_range(0, 1));
        end else begin
            dma_waitrequest = 1'b0;
        end
    end

    function automatic void model_drop(input int n);
        m_drop = (m_drop + n > 65535) ? 65535 : m_drop + n;
        m_und += n;
    endfunction

    // Drives one cycle of strobes and advances the model; returns in the
    // cycle after the DUT sampled them.
    task automatic step_inputs(input bit fs, input bit pd, input logic [1:0] idx);
        bit     acc;
        longint fa;
        @(posedge clk); #1;
        frame_start = fs; prod_done = pd; prod_buf_idx = idx;
        acc = fs && !m_busy && cfg_enable && (cfg_frame_words != 0);
        if (pd && idx < NB) begin
            m_latest = idx;
            m_fresh  = 1;
        end
        if (acc) begin
            if (m_fresh) m_cur = m_latest;
            m_fresh = 0;
            fa = (longint'(cfg_base_addr) + longint'(m_cur) * longint'(cfg_buf_stride))
                 % (longint'(1) << AW);
            push_ev(0, 5'h00, 32'(fa));
            push_ev(0, 5'h04, {2'b00, cfg_frame_words});
            push_ev(0, 5'h08, 32'h1);
            push_ev(0, 5'h08, 32'h0);
            push_ev(1, 5'h00, 32'h0);
            m_busy = 1;
        end else if (fs) begin
            model_drop(1);
        end
        @(posedge clk); #1;
        frame_start = 0; prod_done = 0;
        check("cur_buf", 32'(cur_buf), 32'(m_cur));
        check("drop_cnt", 32'(drop_cnt), 32'(m_drop));
        if (acc) begin
            check("first_write_latency", 32'(dma_write), 32'h1);
            check("first_write_addr", 32'(dma_address), 32'h0);
        end
    endtask

    task automatic run_beats(input int words, input bit mid_reject, input int stop_at);
        int  cnt = 0;
        int  guard = 0;
        bit  did = 0;
        bit  v, r;
        forever begin
            @(posedge clk); #1;
            if (streaming) break;
            st_valid = 1'($urandom_range(0, 1));
            st_ready = 1'($urandom_range(0, 1));
            if (++guard > 400) begin
                n_chk++; n_fail++;
                $display("FAIL stream_start_timeout: got no enable write expected one");
                st_valid = 0; st_ready = 0;
                return;
            end
        end
        while (cnt < words && cnt < stop_at) begin
            v = ($urandom_range(0, 3) != 0);
            r = ($urandom_range(0, 3) != 0);
            st_valid = v; st_ready = r;
            if (v && r) cnt++;
            if (mid_reject && !did && cnt == words / 2 && cnt < words) begin
                frame_start = 1; did = 1;
                model_drop(1);
            end
            @(posedge clk); #1;
            frame_start = 0;
        end
        st_valid = 0; st_ready = 0;
        streaming = 0;
    endtask

    task automatic wait_idle();
        int guard = 0;
        while (m_busy && guard < 200) begin
            @(posedge clk); #1;
            guard++;
        end
        if (m_busy) begin
            n_chk++; n_fail++;
            $display("FAIL frame_done_timeout: got busy=%0d expected frame_done", busy);
            m_busy = 0;
        end
    endtask

    task automatic do_frame(input int words, input int mode, input bit mid,
                            input bit pd, input logic [1:0] idx);
        cfg_frame_words = 30'(words);
        stall_mode = mode;
        step_inputs(1, pd, idx);
        // The frame in flight must ignore reconfiguration.
        cfg_base_addr   = AW'($urandom);
        cfg_frame_words = 30'($urandom);
        run_beats(words, mid, words);
        wait_idle();
        check("cur_buf_after", 32'(cur_buf), 32'(m_cur));
    endtask

    initial begin
        rst = 1; cfg_enable = 0; cfg_base_addr = '0; cfg_buf_stride = '0;
        cfg_frame_words = 0; frame_start = 0; prod_done = 0; prod_buf_idx = 0;
        st_valid = 0; st_ready = 0; dma_waitrequest = 0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_dma_write", 32'(dma_write), 32'h0);
        check("rst_dma_addr", 32'(dma_address), 32'h0);
        check("rst_dma_data", dma_writedata, 32'h0);
        check("rst_byteenable", 32'(dma_byteenable), 32'hF);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_cur_buf", 32'(cur_buf), 32'h0);
        check("rst_drop_cnt", 32'(drop_cnt), 32'h0);
        check("rst_underrun", 32'(underrun), 32'h0);
        rst = 0;

        // Directed frame, then the same buffer repeated under slave stalls
        cfg_enable = 1;
        cfg_base_addr = 24'h100000; cfg_buf_stride = 24'h040000;
        step_inputs(0, 1, 2'd2);
        do_frame(256, 0, 0, 0, 2'd0);
        cfg_base_addr = 24'h100000;
        do_frame(256, 1, 1, 0, 2'd0);

        // Rejections: disabled, zero-length
        cfg_enable = 0; cfg_frame_words = 30'd16;
        step_inputs(1, 0, 2'd0);
        cfg_enable = 1; cfg_frame_words = 30'd0;
        step_inputs(1, 0, 2'd0);

        // Coincident producer strobe, then an out-of-range index
        cfg_base_addr = 24'h100000;
        do_frame(20, 2, 0, 1, 2'd1);
        step_inputs(0, 1, 2'd3);
        cfg_base_addr = 24'h100000;
        do_frame(12, 0, 0, 0, 2'd0);

        for (int i = 0; i < 5; i++) begin
            logic [1:0] ridx;
            cfg_base_addr  = AW'($urandom);
            cfg_buf_stride = AW'($urandom);
            ridx = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 1) == 1) step_inputs(0, 1, 2'($urandom_range(0, 3)));
            do_frame($urandom_range(2, 40), $urandom_range(0, 2), 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 1)), ridx);
        end

        // Reset mid-stream, then a clean restart
        cfg_base_addr = 24'h200000; cfg_buf_stride = 24'h001000;
        step_inputs(0, 1, 2'd1);
        cfg_frame_words = 30'd64; stall_mode = 0;
        step_inputs(1, 0, 2'd0);
        run_beats(64, 0, 10);
        rst = 1; #1;
        check("abort_dma_write", 32'(dma_write), 32'h0);
        check("abort_busy", 32'(busy), 32'h0);
        check("abort_cur_buf", 32'(cur_buf), 32'h0);
        check("abort_drop_cnt", 32'(drop_cnt), 32'h0);
        check("abort_dma_data", dma_writedata, 32'h0);
        sbq.delete();
        m_latest = 0; m_fresh = 0; m_cur = 0; m_busy = 0; m_drop = 0;
        repeat (2) @(posedge clk);
        #1 rst = 0;
        cfg_base_addr = 24'h200000;
        do_frame(8, 0, 0, 0, 2'd0);

        // Saturation of the drop counter
        cfg_enable = 0;
        @(posedge clk); #1;
        frame_start = 1;
        repeat (65536) @(posedge clk);
        #1 frame_start = 0;
        model_drop(65536);
        check("drop_cnt_sat", 32'(drop_cnt), 32'(m_drop));
        step_inputs(1, 0, 2'd0);

        repeat (4) @(posedge clk);
        #1;
        check("underrun_pulses", 32'(und_seen), 32'(m_und));
        check("scoreboard_empty", 32'(sbq.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
